lcd_frame_sched: RTL and testbench

LCD_FRAME_SCHED -- requirements
Module: lcd_frame_sched

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_frame_sched_if.sv | 23 ++
 rtl/lcd_bank_clear.sv | 41 ++++
 rtl/lcd_frame_sched.sv | 152 +++++++++++++++
 tb/tb_lcd_frame_sched.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame scheduler and its clear engine.
package lcd_pkg;
  localparam int LCD_ADDR_W = 10;
  localparam int LCD_DATA_W = 8;

  typedef logic [LCD_ADDR_W-1:0] lcd_addr_t;
  typedef logic [LCD_DATA_W-1:0] lcd_data_t;

  localparam lcd_addr_t LAST_ADDR = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SWAP     = 3'd1,
    START_HI = 3'd2,
    START_LO = 3'd3,
    SCAN     = 3'd4
  } state_e;
endpackage

// File: rtl/lcd_frame_sched_if.sv
// Renderer-side bus: back-bank writes, bank swap handshake and clear request.
interface lcd_frame_sched_if;
  import lcd_pkg::*;

  logic      wr_req_i;
  lcd_addr_t wr_addr_i;
  lcd_data_t wr_data_i;
  logic      wr_gnt_o;
  logic      swap_req_i;
  logic      swap_ack_o;
  logic      clr_req_i;
  logic      clr_busy_o;

  modport master (
    output wr_req_i, wr_addr_i, wr_data_i, swap_req_i, clr_req_i,
    input  wr_gnt_o, swap_ack_o, clr_busy_o
  );

  modport slave (
    input  wr_req_i, wr_addr_i, wr_data_i, swap_req_i, clr_req_i,
    output wr_gnt_o, swap_ack_o, clr_busy_o
  );
endinterface

// File: rtl/lcd_bank_clear.sv
// Zero-fill engine: walks every bank address once, one per cycle, after a start pulse.
module lcd_bank_clear
  import lcd_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      start_i,
  output logic      busy_o,
  output lcd_addr_t addr_o
);

  logic      busy_q, busy_d;
  lcd_addr_t cnt_q, cnt_d;

  // A start while busy is dropped; the counter wraps back to 0 on its last step.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      cnt_d = cnt_q + lcd_addr_t'(1);
      if (cnt_q == LAST_ADDR) busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign addr_o = cnt_q;

endmodule

// File: rtl/lcd_frame_sched.sv
// Double-buffered LCD frame scheduler: refresh ticks, bank swap, driver start and frame supervision.
module lcd_frame_sched
  import lcd_pkg::*;
#(
  parameter logic [31:0] REFRESH_CYC   = 32'd1_000_000,
  parameter logic [31:0] FRAME_TIMEOUT = 32'd4096
) (
  input  logic      clk,
  input  logic      rstn,
  output logic      drv_start_o,
  input  lcd_addr_t drv_addr_i,
  input  logic      drv_dori_i,
  output lcd_data_t drv_data_o,
  output lcd_addr_t bank0_addr_o,
  output lcd_addr_t bank1_addr_o,
  output logic      bank0_we_o,
  output logic      bank1_we_o,
  output lcd_data_t bank0_wdata_o,
  output lcd_data_t bank1_wdata_o,
  input  lcd_data_t bank0_rdata_i,
  input  lcd_data_t bank1_rdata_i,
  output logic      front_o,
  output logic      frame_done_o,
  output logic      timeout_o,
  lcd_frame_sched_if.slave rnd
);

  state_e      state_q, state_d;
  logic [31:0] ref_cnt_q, ref_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tick_pend_q, tick_pend_d;
  logic        front_q, front_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic        clr_busy, wr_gnt, frame_end;
  lcd_addr_t   clr_addr, back_addr;
  logic        back_we;
  lcd_data_t   back_wdata;

  lcd_bank_clear u_clear (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (rnd.clr_req_i),
    .busy_o  (clr_busy),
    .addr_o  (clr_addr)
  );

  // End of frame: address returns to 0 right after the last data-phase column.
  assign frame_end = last_q && (drv_addr_i == '0);

  always_comb begin
    state_d     = state_q;
    tick_pend_d = tick_pend_q;
    front_d     = front_q;
    tmo_cnt_d   = tmo_cnt_q;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    last_d      = (state_q == SCAN) && (drv_addr_i == LAST_ADDR) && drv_dori_i;
    ref_cnt_d   = ref_cnt_q + 32'd1;

    if (state_q == IDLE && tick_pend_q) tick_pend_d = 1'b0;
    // A fresh tick wins over the clear-on-leave so it is never lost.
    if (ref_cnt_q == REFRESH_CYC - 32'd1) begin
      ref_cnt_d   = '0;
      tick_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick_pend_q) state_d = (rnd.swap_req_i && !clr_busy) ? SWAP : START_HI;
      end
      SWAP: begin
        front_d = ~front_q;
        state_d = START_HI;
      end
      START_HI: state_d = START_LO;
      START_LO: begin
        tmo_cnt_d = FRAME_TIMEOUT - 32'd1;
        state_d   = SCAN;
      end
      SCAN: begin
        if (frame_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt_q == '0) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ref_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      tick_pend_q <= 1'b0;
      front_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tick_pend_q <= tick_pend_d;
      front_q     <= front_d;
      last_q      <= last_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
    end
  end

  // rstn gates the grant so no write slips through while reset is held.
  assign wr_gnt         = rstn && rnd.wr_req_i && !clr_busy && (state_q != SWAP);
  assign rnd.wr_gnt_o   = wr_gnt;
  assign rnd.swap_ack_o = (state_q == SWAP);
  assign rnd.clr_busy_o = clr_busy;
  assign drv_start_o    = (state_q == START_HI);
  assign frame_done_o   = done_q;
  assign timeout_o      = tmo_q;
  assign front_o        = front_q;

  assign back_addr  = clr_busy ? clr_addr : rnd.wr_addr_i;
  assign back_we    = clr_busy || wr_gnt;
  assign back_wdata = clr_busy ? '0 : rnd.wr_data_i;

  lcd_addr_t bank_addr  [2];
  logic      bank_we    [2];
  lcd_data_t bank_wdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic IDX = 1'(gi);
    assign bank_addr[gi]  = (front_q == IDX) ? drv_addr_i : back_addr;
    assign bank_we[gi]    = (front_q == IDX) ? 1'b0 : back_we;
    assign bank_wdata[gi] = (front_q == IDX) ? '0 : back_wdata;
  end

  assign bank0_addr_o  = bank_addr[0];
  assign bank1_addr_o  = bank_addr[1];
  assign bank0_we_o    = bank_we[0];
  assign bank1_we_o    = bank_we[1];
  assign bank0_wdata_o = bank_wdata[0];
  assign bank1_wdata_o = bank_wdata[1];
  assign drv_data_o    = front_q ? bank1_rdata_i : bank0_rdata_i;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Directed bench for lcd_frame_sched with bank RAM models and a simple LCD driver model.
module tb_lcd_frame_sched;
  import lcd_pkg::*;

  localparam logic [31:0] RC = 32'd100;
  localparam logic [31:0] FT = 32'd1100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lcd_frame_sched_if rnd ();

  logic      drv_start, drv_dori, front, frame_done, timeout;
  lcd_addr_t drv_addr, b0_addr, b1_addr;
  logic      b0_we, b1_we;
  lcd_data_t drv_data, b0_wdata, b1_wdata, b0_rdata, b1_rdata;

  lcd_frame_sched #(.REFRESH_CYC(RC), .FRAME_TIMEOUT(FT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .drv_start_o   (drv_start),
    .drv_addr_i    (drv_addr),
    .drv_dori_i    (drv_dori),
    .drv_data_o    (drv_data),
    .bank0_addr_o  (b0_addr),
    .bank1_addr_o  (b1_addr),
    .bank0_we_o    (b0_we),
    .bank1_we_o    (b1_we),
    .bank0_wdata_o (b0_wdata),
    .bank1_wdata_o (b1_wdata),
    .bank0_rdata_i (b0_rdata),
    .bank1_rdata_i (b1_rdata),
    .front_o       (front),
    .frame_done_o  (frame_done),
    .timeout_o     (timeout),
    .rnd           (rnd)
  );

  // Bank RAMs: asynchronous read, write on the rising edge.
  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  assign b0_rdata = mem0[b0_addr];
  assign b1_rdata = mem1[b1_addr];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 8'(i) ^ 8'hA5;
      mem1[i] = 8'hFF;
    end
    forever begin
      @(posedge clk);
      if (b0_we) mem0[b0_addr] = b0_wdata;
      if (b1_we) mem1[b1_addr] = b1_wdata;
    end
  end

  // Driver model: on the falling edge of start, stream columns 0..3FF in data phase.
  logic      drv_en = 1'b1, drv_stall = 1'b0, stream = 1'b0, prev_start = 1'b0;
  lcd_addr_t s_addr = '0, idle_addr = '0;
  always @(negedge clk) begin
    if (!drv_en) stream = 1'b0;
    else if (prev_start && !drv_start) begin
      stream = 1'b1;
      s_addr = '0;
    end else if (stream) begin
      if (drv_stall && s_addr == 10'h155) s_addr = s_addr;
      else if (s_addr == LAST_ADDR) begin
        s_addr = '0;
        stream = 1'b0;
      end else s_addr = s_addr + 10'd1;
    end
    prev_start = drv_start;
  end
  assign drv_addr = stream ? s_addr : idle_addr;
  assign drv_dori = stream;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else $display("ok   %s: %0h", name, act);
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return drv_start;
      1:       return frame_done;
      2:       return timeout;
      default: return rnd.swap_ack_o;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk); #1;
      n++;
      if (sig_sel(which)) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no pulse within %0d cycles", name, limit);
  endtask

  typedef struct {
    logic      wr_req;
    lcd_addr_t wr_addr;
    lcd_data_t wr_data;
    lcd_addr_t drv_addr;
    logic      gnt;
    lcd_addr_t b0_addr;
    lcd_addr_t b1_addr;
    logic      b1_we;
    lcd_data_t b1_wdata;
    lcd_data_t data;
  } vec_t;

  vec_t vec [5];

  initial begin
    int n, busy_n, bad, ack_in_clear, nz;
    vec[0] = '{1'b1, 10'h000, 8'h11, 10'h012, 1'b1, 10'h012, 10'h000, 1'b1, 8'h11, 8'hB7};
    vec[1] = '{1'b1, 10'h3FF, 8'h22, 10'h3FF, 1'b1, 10'h3FF, 10'h3FF, 1'b1, 8'h22, 8'h5A};
    vec[2] = '{1'b0, 10'h155, 8'h33, 10'h000, 1'b0, 10'h000, 10'h155, 1'b0, 8'h33, 8'hA5};
    vec[3] = '{1'b1, 10'h2AA, 8'h44, 10'h2AA, 1'b1, 10'h2AA, 10'h2AA, 1'b1, 8'h44, 8'h0F};
    vec[4] = '{1'b1, 10'h001, 8'h55, 10'h080, 1'b1, 10'h080, 10'h001, 1'b1, 8'h55, 8'h25};

    rnd.wr_req_i = 1'b1; rnd.wr_addr_i = '0; rnd.wr_data_i = '0;
    rnd.swap_req_i = 1'b1; rnd.clr_req_i = 1'b1;

    // Reset values with every request input active.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_front", 32'(front), 32'd0);
    chk("rst_clr_busy", 32'(rnd.clr_busy_o), 32'd0);
    chk("rst_drv_start", 32'(drv_start), 32'd0);
    chk("rst_swap_ack", 32'(rnd.swap_ack_o), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_wr_gnt", 32'(rnd.wr_gnt_o), 32'd0);
    chk("rst_b1_we", 32'(b1_we), 32'd0);

    @(negedge clk);
    rnd.wr_req_i = 1'b0; rnd.swap_req_i = 1'b0; rnd.clr_req_i = 1'b0;
    rstn = 1'b1;

    // First tick: start strobe at edge RC+1, frame done 1026 edges later.
    wait_for("first_start", 0, 300, n);
    chk("start_latency", 32'(n), 32'd101);
    @(posedge clk); #1;
    chk("start_width", 32'(drv_start), 32'd0);
    wait_for("frame_done", 1, 1500, n);
    chk("frame_done_latency", 32'(n + 1), 32'd1026);
    drv_stall = 1'b1;
    @(posedge clk); #1;
    chk("frame_done_width", 32'(frame_done), 32'd0);
    chk("pending_tick_start", 32'(drv_start), 32'd1);

    // Driver stalls at 0x155: timeout FT+2 edges after the start strobe.
    wait_for("timeout", 2, 1500, n);
    chk("timeout_latency", 32'(n), FT + 32'd2);
    drv_en = 1'b0; drv_stall = 1'b0;
    @(posedge clk); #1;
    chk("timeout_width", 32'(timeout), 32'd0);
    chk("idle_after_timeout", 32'(drv_start), 32'd1);

    // Routing with front = 0: bank1 is the write target.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rnd.wr_req_i = vec[i].wr_req; rnd.wr_addr_i = vec[i].wr_addr;
      rnd.wr_data_i = vec[i].wr_data; idle_addr = vec[i].drv_addr;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(rnd.wr_gnt_o), 32'(vec[i].gnt));
      chk($sformatf("v%0d_b0_addr", i), 32'(b0_addr), 32'(vec[i].b0_addr));
      chk($sformatf("v%0d_b0_we", i), 32'(b0_we), 32'd0);
      chk($sformatf("v%0d_b1_addr", i), 32'(b1_addr), 32'(vec[i].b1_addr));
      chk($sformatf("v%0d_b1_we", i), 32'(b1_we), 32'(vec[i].b1_we));
      chk($sformatf("v%0d_b1_wdata", i), 32'(b1_wdata), 32'(vec[i].b1_wdata));
      chk($sformatf("v%0d_drv_data", i), 32'(drv_data), 32'(vec[i].data));
    end

    // Swap: writes blocked during SWAP, front flips, start follows.
    @(negedge clk);
    rnd.wr_req_i = 1'b1; rnd.wr_addr_i = 10'h010; rnd.wr_data_i = 8'h66;
    rnd.swap_req_i = 1'b1; idle_addr = '0;
    wait_for("swap_ack", 3, 2500, n);
    chk("swap_front_before", 32'(front), 32'd0);
    chk("swap_gnt_blocked", 32'(rnd.wr_gnt_o), 32'd0);
    chk("swap_no_start", 32'(drv_start), 32'd0);
    @(negedge clk);
    rnd.swap_req_i = 1'b0; rnd.wr_req_i = 1'b0;
    @(posedge clk); #1;
    chk("swap_ack_width", 32'(rnd.swap_ack_o), 32'd0);
    chk("swap_front_after", 32'(front), 32'd1);
    chk("swap_then_start", 32'(drv_start), 32'd1);

    // Front bank 1 now shows what was written into it.
    @(negedge clk); idle_addr = 10'h3FF; #1; chk("rd_3ff", 32'(drv_data), 32'h22);
    @(negedge clk); idle_addr = 10'h2AA; #1; chk("rd_2aa", 32'(drv_data), 32'h44);
    @(negedge clk); idle_addr = 10'h010; #1; chk("rd_010", 32'(drv_data), 32'h66);
    @(negedge clk); idle_addr = 10'h001; #1; chk("rd_001", 32'(drv_data), 32'h55);
    chk("front_b1_we", 32'(b1_we), 32'd0);

    // Clear of bank0 with writes held, a repeated clear request and a swap request mid-clear.
    @(negedge clk);
    idle_addr = '0;
    rnd.wr_req_i = 1'b1; rnd.wr_addr_i = 10'h005; rnd.wr_data_i = 8'h77; rnd.clr_req_i = 1'b1;
    #1;
    chk("gnt_before_clear", 32'(rnd.wr_gnt_o), 32'd1);
    @(negedge clk);
    rnd.clr_req_i = 1'b0;
    busy_n = 0; bad = 0; ack_in_clear = 0;
    for (int k = 0; k < 1100; k++) begin
      #1;
      if (rnd.clr_busy_o) begin
        if (b0_addr !== 10'(busy_n) || b0_we !== 1'b1 || b0_wdata !== 8'h00 ||
            rnd.wr_gnt_o !== 1'b0 || b1_we !== 1'b0) bad++;
        if (rnd.swap_ack_o) ack_in_clear++;
        busy_n++;
      end else if (busy_n > 0) break;
      @(negedge clk);
      rnd.clr_req_i = (busy_n == 500);
      if (busy_n >= 300) rnd.swap_req_i = 1'b1;
    end
    chk("clear_busy_cycles", 32'(busy_n), 32'd1024);
    chk("clear_bad_cycles", 32'(bad), 32'd0);
    chk("clear_no_swap", 32'(ack_in_clear), 32'd0);
    chk("gnt_resumed", 32'(rnd.wr_gnt_o), 32'd1);
    @(negedge clk);
    rnd.wr_req_i = 1'b0;
    nz = 0;
    for (int i = 0; i < 1024; i++) if (i != 5 && mem0[i] !== 8'h00) nz++;
    chk("bank0_zeroed", 32'(nz), 32'd0);
    chk("bank0_write_after_clear", 32'(mem0[5]), 32'h77);

    wait_for("deferred_swap", 3, 2500, n);
    chk("deferred_swap_not_busy", 32'(rnd.clr_busy_o), 32'd0);
    @(negedge clk);
    rnd.swap_req_i = 1'b0;
    @(posedge clk); #1;
    chk("deferred_front", 32'(front), 32'd0);

    // Reset in the middle of a clear with front = 1.
    @(negedge clk);
    rnd.swap_req_i = 1'b1;
    wait_for("swap_pre_rst", 3, 2500, n);
    @(negedge clk);
    rnd.swap_req_i = 1'b0;
    @(posedge clk); #1;
    chk("front_before_rst", 32'(front), 32'd1);
    @(negedge clk); rnd.clr_req_i = 1'b1;
    @(negedge clk); rnd.clr_req_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_rst", 32'(rnd.clr_busy_o), 32'd1);
    rstn = 1'b0; rnd.wr_req_i = 1'b1;
    #1;
    chk("midrst_front", 32'(front), 32'd0);
    chk("midrst_clr_busy", 32'(rnd.clr_busy_o), 32'd0);
    chk("midrst_drv_start", 32'(drv_start), 32'd0);
    chk("midrst_swap_ack", 32'(rnd.swap_ack_o), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    chk("midrst_wr_gnt", 32'(rnd.wr_gnt_o), 32'd0);
    chk("midrst_bank_we", 32'({b0_we, b1_we}), 32'd0);
    @(negedge clk);
    rstn = 1'b1; rnd.wr_req_i = 1'b0; rnd.wr_addr_i = 10'h123;
    nz = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (rnd.clr_busy_o !== 1'b0 || b1_we !== 1'b0) nz++;
    end
    chk("no_clear_resume", 32'(nz), 32'd0);
    chk("back_addr_after_rst", 32'(b1_addr), 32'h123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
